// File: rtl/shift_unit_controller_if.sv
// Request/response bundle for the shared shifter controller: two request ports
// and one registered response slot, all under valid/ready handshakes.
interface shift_unit_controller_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [1:0]  req0_op;
    logic [31:0] req0_data;
    logic [4:0]  req0_amt;

    logic        req1_valid;
    logic        req1_ready;
    logic [1:0]  req1_op;
    logic [31:0] req1_data;
    logic [4:0]  req1_amt;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_id;

    modport master (
        output req0_valid, req0_op, req0_data, req0_amt,
        input  req0_ready,
        output req1_valid, req1_op, req1_data, req1_amt,
        input  req1_ready,
        input  resp_valid, resp_data, resp_id,
        output resp_ready
    );

    modport slave (
        input  req0_valid, req0_op, req0_data, req0_amt,
        output req0_ready,
        input  req1_valid, req1_op, req1_data, req1_amt,
        output req1_ready,
        output resp_valid, resp_data, resp_id,
        input  resp_ready
    );
endinterface

// File: rtl/shift_unit_controller.sv
// Round-robin controller for one shared 32-bit right shifter; SLL/SRA/ROTR are
// built from right-shift passes with bit-reversal and inversion around the shifter.
module barrel_right_shifter (
    input  logic [31:0] i_data,
    input  logic [4:0]  i_amt,
    output logic [31:0] o_data
);
    assign o_data = i_data >> i_amt;
endmodule

module shift_unit_controller (
    input  logic             clock,
    input  logic             reset,
    shift_unit_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;
    typedef enum logic [1:0] {OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_ROTR = 2'b11} op_t;

    state_t      r_state;
    logic        r_last;
    op_t         r_op;
    logic [31:0] r_data;
    logic [4:0]  r_amt;
    logic        r_id;
    logic [31:0] r_partial;
    logic        r_resp_valid;
    logic [31:0] r_resp_data;
    logic        r_resp_id;

    logic        w_grant;
    logic        w_hs;
    logic [31:0] w_sh_in;
    logic [4:0]  w_sh_amt;
    logic [31:0] w_sh_out;
    logic [31:0] w_result;
    logic        w_invert;

    function automatic logic [31:0] bitrev(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++)
            r[i] = v[31 - i];
        return r;
    endfunction

    // On contention the port that did not win last time gets the shifter.
    always_comb begin
        w_grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid)
            w_grant = ~r_last;
        else
            w_grant = bus.req1_valid;
    end

    assign bus.req0_ready = (r_state == IDLE) && bus.req0_valid && !w_grant;
    assign bus.req1_ready = (r_state == IDLE) && bus.req1_valid && w_grant;
    assign w_hs = (bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready);

    assign w_invert = (r_op == OP_SRA) && r_data[31];

    // PASS2 is the left half of a rotate: reversed data, shifted by -amt mod 32.
    always_comb begin
        w_sh_in  = r_data;
        w_sh_amt = r_amt;
        if (r_state == PASS2) begin
            w_sh_in  = bitrev(r_data);
            w_sh_amt = 5'd0 - r_amt;
        end else if (r_op == OP_SLL) begin
            w_sh_in = bitrev(r_data);
        end else if (w_invert) begin
            w_sh_in = ~r_data;
        end
    end

    barrel_right_shifter u_shifter (
        .i_data (w_sh_in),
        .i_amt  (w_sh_amt),
        .o_data (w_sh_out)
    );

    always_comb begin
        w_result = w_sh_out;
        if (r_state == PASS2)
            w_result = r_partial | bitrev(w_sh_out);
        else if (r_op == OP_SLL)
            w_result = bitrev(w_sh_out);
        else if (w_invert)
            w_result = ~w_sh_out;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last       <= 1'b1;
            r_op         <= OP_SLL;
            r_data       <= '0;
            r_amt        <= '0;
            r_id         <= 1'b0;
            r_partial    <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_id    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_op    <= op_t'(w_grant ? bus.req1_op : bus.req0_op);
                        r_data  <= w_grant ? bus.req1_data : bus.req0_data;
                        r_amt   <= w_grant ? bus.req1_amt : bus.req0_amt;
                        r_id    <= w_grant;
                        r_last  <= w_grant;
                        r_state <= PASS1;
                    end
                end
                PASS1: begin
                    if (r_op == OP_ROTR) begin
                        r_partial <= w_sh_out;
                        r_state   <= PASS2;
                    end else begin
                        r_resp_data  <= w_result;
                        r_resp_id    <= r_id;
                        r_resp_valid <= 1'b1;
                        r_state      <= DONE;
                    end
                end
                PASS2: begin
                    r_resp_data  <= w_result;
                    r_resp_id    <= r_id;
                    r_resp_valid <= 1'b1;
                    r_state      <= DONE;
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_id    = r_resp_id;
endmodule

// File: tb/tb_shift_unit_controller.sv
// Scoreboard bench for shift_unit_controller: expected results are queued at each
// request handshake and compared when the response is consumed.
module tb_shift_unit_controller;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    shift_unit_controller_if bus();

    shift_unit_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic        id;
        int          lat;
        int          n_h;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [4:0]  amt;
        logic [31:0] res;
    } vec_t;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;
    exp_t        sb[$];
    logic        grant_log[$];
    logic [31:0] exp_next[2];
    int          exp_lat[2];
    int          ncnt = 0;
    logic        prev_valid = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d, input logic [4:0] a);
        logic [63:0] dd;
        case (op)
            2'b00:   return d << a;
            2'b01:   return d >> a;
            2'b10:   return $signed(d) >>> a;
            default: begin
                dd = {d, d} >> a;
                return dd[31:0];
            end
        endcase
    endfunction

    // Monitor: latency on response rise, data/id on consumption, push on grant.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            sb.delete();
            prev_valid = 1'b0;
        end else begin
            ncnt++;
            check_eq("ready_excl", {31'b0, bus.req0_ready & bus.req1_ready}, 32'd0);
            if (bus.resp_valid && !prev_valid) begin
                if (sb.size() == 0)
                    check_eq("stale_resp", 32'd1, 32'd0);
                else
                    check_eq("latency", ncnt - sb[0].n_h, sb[0].lat);
            end
            if (bus.resp_valid && bus.resp_ready && sb.size() > 0) begin
                e = sb.pop_front();
                check_eq("resp_data", bus.resp_data, e.data);
                check_eq("resp_id", {31'b0, bus.resp_id}, {31'b0, e.id});
            end
            if (bus.req0_valid && bus.req0_ready) begin
                e.data = exp_next[0]; e.id = 1'b0; e.lat = exp_lat[0]; e.n_h = ncnt;
                sb.push_back(e);
                grant_log.push_back(1'b0);
            end
            if (bus.req1_valid && bus.req1_ready) begin
                e.data = exp_next[1]; e.id = 1'b1; e.lat = exp_lat[1]; e.n_h = ncnt;
                sb.push_back(e);
                grant_log.push_back(1'b1);
            end
            prev_valid = bus.resp_valid;
        end
    end

    task automatic drive_port(input int port, input logic v, input logic [1:0] op,
                              input logic [31:0] data, input logic [4:0] amt);
        if (port == 0) begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_data = data; bus.req0_amt = amt;
        end else begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_data = data; bus.req1_amt = amt;
        end
    endtask

    // Called just after a rising edge; returns just after the handshake edge.
    task automatic issue(input int port, input logic [1:0] op, input logic [31:0] data,
                         input logic [4:0] amt, input logic [31:0] expd);
        bit ok;
        exp_next[port] = expd;
        exp_lat[port]  = (op == 2'b11) ? 3 : 2;
        drive_port(port, 1'b1, op, data, amt);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            if (port == 0) ok = bus.req0_valid && bus.req0_ready;
            else           ok = bus.req1_valid && bus.req1_ready;
        end
        if (!ok) check_eq("hs_timeout", 32'd1, 32'd0);
        @(posedge clock);
        #1;
        // Scramble the port after handshake; the in-flight op must not notice.
        drive_port(port, 1'b0, 2'($urandom), ~data, 5'($urandom));
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) check_eq("drain_timeout", sb.size(), 32'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    vec_t vecs[10] = '{
        '{2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000},
        '{2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000},
        '{2'b10, 32'h7000_0000, 5'd4,  32'h0700_0000},
        '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000},
        '{2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF},
        '{2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF},
        '{2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF},
        '{2'b11, 32'h1234_5678, 5'd8,  32'h7812_3456},
        '{2'b11, 32'h1234_5678, 5'd0,  32'h1234_5678},
        '{2'b11, 32'h1234_5678, 5'd31, 32'h2468_ACF0}
    };

    initial begin
        logic [1:0]  op;
        logic [31:0] d;
        logic [4:0]  a;
        int          port;
        bit          seen;

        drive_port(0, 1'b0, 2'b00, '0, '0);
        drive_port(1, 1'b0, 2'b00, '0, '0);
        bus.resp_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_ready0", {31'b0, bus.req0_ready}, 32'd0);
        check_eq("rst_ready1", {31'b0, bus.req1_ready}, 32'd0);
        check_eq("rst_valid", {31'b0, bus.resp_valid}, 32'd0);
        check_eq("rst_data", bus.resp_data, 32'd0);
        check_eq("rst_id", {31'b0, bus.resp_id}, 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        foreach (vecs[i]) begin
            issue(i % 2, vecs[i].op, vecs[i].data, vecs[i].amt, vecs[i].res);
            wait_drain();
        end

        for (int i = 0; i < 20; i++) begin
            op = 2'($urandom); d = $urandom; a = 5'($urandom); port = $urandom_range(0, 1);
            issue(port, op, d, a, ref_shift(op, d, a));
            wait_drain();
        end

        // Arbitration: both ports held valid from reset
        do_reset();
        grant_log.delete();
        exp_next[0] = 32'h0000_8000; exp_lat[0] = 2;
        exp_next[1] = 32'h0000_0C00; exp_lat[1] = 2;
        drive_port(0, 1'b1, 2'b01, 32'h0001_0000, 5'd1);
        drive_port(1, 1'b1, 2'b00, 32'h0000_0003, 5'd10);
        for (int i = 0; i < 100 && grant_log.size() < 4; i++) @(negedge clock);
        @(posedge clock);
        #1;
        drive_port(0, 1'b0, 2'b00, '0, '0);
        drive_port(1, 1'b0, 2'b00, '0, '0);
        check_eq("arb_count", grant_log.size(), 32'd4);
        if (grant_log.size() >= 4) begin
            check_eq("arb_g0", {31'b0, grant_log[0]}, 32'd0);
            check_eq("arb_g1", {31'b0, grant_log[1]}, 32'd1);
            check_eq("arb_g2", {31'b0, grant_log[2]}, 32'd0);
            check_eq("arb_g3", {31'b0, grant_log[3]}, 32'd1);
        end
        wait_drain();

        // Backpressure: DONE held while port 1 waits
        bus.resp_ready = 1'b0;
        grant_log.delete();
        issue(0, 2'b01, 32'hF0F0_0000, 5'd8, 32'h00F0_F000);
        fork
            issue(1, 2'b00, 32'h0000_0001, 5'd4, 32'h0000_0010);
        join_none
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            seen = bus.resp_valid;
        end
        check_eq("bp_valid_seen", {31'b0, seen}, 32'd1);
        repeat (5) begin
            @(negedge clock);
            check_eq("bp_data", bus.resp_data, 32'h00F0_F000);
            check_eq("bp_valid", {31'b0, bus.resp_valid}, 32'd1);
            check_eq("bp_ready0", {31'b0, bus.req0_ready}, 32'd0);
            check_eq("bp_ready1", {31'b0, bus.req1_ready}, 32'd0);
        end
        @(posedge clock);
        #1;
        bus.resp_ready = 1'b1;
        wait fork;
        wait_drain();
        check_eq("bp_next_grant", grant_log.size(), 32'd2);
        if (grant_log.size() == 2)
            check_eq("bp_next_id", {31'b0, grant_log[1]}, 32'd1);

        // Reset during PASS2 of a rotate
        issue(0, 2'b11, 32'h1234_5678, 5'd8, 32'h7812_3456);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_valid", {31'b0, bus.resp_valid}, 32'd0);
        @(negedge clock);
        check_eq("mid_rst_ready0", {31'b0, bus.req0_ready}, 32'd0);
        check_eq("mid_rst_ready1", {31'b0, bus.req1_ready}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        grant_log.delete();
        fork
            issue(0, 2'b10, 32'h8000_0001, 5'd1, 32'hC000_0000);
            issue(1, 2'b11, 32'h0000_00FF, 5'd4, 32'hF000_000F);
        join
        wait_drain();
        check_eq("post_rst_count", grant_log.size(), 32'd2);
        if (grant_log.size() == 2)
            check_eq("post_rst_first", {31'b0, grant_log[0]}, 32'd0);
        repeat (5) @(negedge clock);
        check_eq("post_rst_idle_valid", {31'b0, bus.resp_valid}, 32'd0);
        check_eq("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/shift_unit_controller.md
# shift_unit_controller

Sequencing and arbitration controller for the processor's single shared 32-bit barrel right shifter. Accepts shift requests from two requesters (port 0: ALU issue, port 1: multdiv/auxiliary path), grants the shifter round-robin, and implements SLL, SRL, SRA and ROTR using only right-shift passes with input/output conditioning. Results sit in a registered response slot under a valid/ready handshake. It instantiates exactly one `barrel_right_shifter`; no other shift logic is permitted in the block.

## Interface
- No parameters; width fixed at 32 data bits, 5 amount bits.
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `req0_valid` in 1: port 0 request present.
- `req0_ready` out 1: port 0 request accepted this cycle when high with `req0_valid`.
- `req0_op` in 2: 00 SLL, 01 SRL, 10 SRA, 11 ROTR.
- `req0_data` in 32: operand.
- `req0_amt` in 5: shift amount 0–31.
- `req1_valid`, `req1_ready`, `req1_op`, `req1_data`, `req1_amt`: identical meaning for port 1.
- `resp_valid` out 1: result available.
- `resp_ready` in 1: consumer takes result when high with `resp_valid`.
- `resp_data` out 32: shift result.
- `resp_id` out 1: port that issued the request.

## Operation
- FSM states: IDLE, PASS1, PASS2, DONE. Reset state IDLE.
- Grant pointer `last` (1 bit), reset to 1, so port 0 wins the first contention.
- IDLE: grant = only valid port; if both valid, grant = port != `last`. `reqN_ready` = (state==IDLE) && grant==N, combinational. Never both high. On handshake: latch op, data, amt, id; set `last` = granted port; go to PASS1.
- PASS1 shifter input/amount by op:
  - SRL: data, amt; result = shifter out.
  - SRA: data[31]=0 as SRL; data[31]=1: input ~data, result = ~shifter out (sign fill).
  - SLL: input bit-reversed data, result = bit-reverse of shifter out.
  - ROTR: data, amt; shifter out stored in partial register; go to PASS2.
  - Non-ROTR: result register loaded, go to DONE.
- PASS2 (ROTR only): SLL-style pass of latched data by (32 − amt) mod 32 (5-bit two's complement of amt); result = partial | pass2 out. amt=0 yields data unchanged without special case.
- DONE: `resp_valid`=1, `resp_data`/`resp_id` stable; on `resp_ready` go to IDLE. No new request accepted until IDLE.
- Amount arithmetic is strictly 5-bit; no values ≥32 exist.

## Timing
- Reset values: `req0_ready`=0 and `req1_ready`=0 only while no request valid (combinational from state IDLE), `resp_valid`=0, `resp_data`=0, `resp_id`=0, `last`=1, state IDLE.
- Accept at edge T → `resp_valid` high from T+2 (SLL/SRL/SRA) or T+3 (ROTR).
- Minimum issue interval 3 cycles (single-pass, `resp_ready` held high): IDLE, PASS1, DONE.
- Backpressure: DONE holds indefinitely; outputs unchanged; both `reqN_ready` low.
- Request inputs are sampled only at the handshake edge; later changes on a port do not affect the in-flight operation.
- Reset asserted in any state: immediately IDLE, `resp_valid`=0, in-flight op discarded, `last`=1; no response is ever produced for it.
- Requester dropping `valid` before handshake: no grant, `last` unchanged.

## Test plan
- SRL: port 0, op 01, data 0x8000_0000, amt 4 → `resp_data` 0x0800_0000, `resp_id` 0, `resp_valid` at T+2.
- SRA/SLL: op 10, 0x8000_0000, amt 4 → 0xF800_0000; op 10, 0x7000_0000, amt 4 → 0x0700_0000; op 00, 0x0000_0001, amt 31 → 0x8000_0000; any op with amt 0 → data unchanged.
- ROTR: op 11, 0x1234_5678, amt 8 → 0x7812_3456 at T+3; amt 0 → 0x1234_5678; amt 31 → 0x2468_ACF0.
- Arbitration: both ports valid continuously from reset with `resp_ready`=1 → grants 0,1,0,1; `resp_id` alternates; ready never both high.
- Backpressure: `resp_ready`=0 for 5 cycles in DONE → `resp_data` stable, both ready low; release → IDLE next cycle, next grant follows.
- Reset mid-ROTR (asserted during PASS2) → `resp_valid` 0, state IDLE; after release, port 0 wins contention; no stale response appears.
